mips_controller: RTL and testbench
==================================

// Module: mips_controller
// PURPOSE
//  Multicycle MIPS control unit: Moore FSM plus ALU decoder. Sits opposite the multicycle datapath.
//  Consumes Opcode/Funct from the instruction register and drives every datapath select and write enable.
//  Sequences lw, sw, R-type (add/sub/and/or/slt), beq and, optionally, addi over 3-5 cycles each.
// PARAMETERS
//  BRANCH_SRCB  2'b11  ALUSrcB code used in DECODE to form the branch target (11 = SignImm<<2).
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high; forces state to FETCH
//  Opcode      in   6  instr[31:26] from the IR
//  Funct       in   6  instr[5:0] from the IR
//  MemToReg    out  1  0=ALUOut, 1=Data to WD3
//  RegDst      out  1  0=rt (A2), 1=rd (A3) as write address
//  IorD        out  1  0=PC, 1=ALUOut as memory address
//  PCSrc       out  1  0=ALUResult, 1=ALUOut into PC
//  ALUSrcA     out  1  0=PC, 1=A
//  ALUSrcB     out  2  00=B, 01=const 1, 10=SignImm, 11=SignImm<<2
//  ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  IRWrite, MemWrite, PCWrite, Branch, RegWrite  out  1 each  write enables
//  state       out  4  current FSM state (debug)
//  illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct
// BEHAVIOUR
//  - States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6,
//    ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10. All other codes go to FETCH on the next edge.
//  - Outputs are Moore decodes of state. ALUControl also depends on Funct when ALUOp=10.
//    Any signal not listed for a state is 0.
//  - FETCH:    IorD=0 SrcA=0 SrcB=01 ALUOp=00 PCSrc=0 IRWrite=1 PCWrite=1 -> DECODE
//  - DECODE:   SrcA=0 SrcB=BRANCH_SRCB ALUOp=00
//      lw(100011)/sw(101011) -> MEMADR; R(000000) -> EXECUTE; beq(000100) -> BRANCH;
//      addi(001000) -> ADDIEX (macro only); else illegal_op=1 -> FETCH.
//  - MEMADR:   SrcA=1 SrcB=10 ALUOp=00; lw -> MEMREAD, sw -> MEMWRITE
//  - MEMREAD:  IorD=1 -> MEMWB
//  - MEMWB:    RegDst=0 MemToReg=1 RegWrite=1 -> FETCH
//  - MEMWRITE: IorD=1 MemWrite=1 -> FETCH
//  - EXECUTE:  SrcA=1 SrcB=00 ALUOp=10 -> ALUWB
//  - ALUWB:    RegDst=1 MemToReg=0 RegWrite=1 -> FETCH
//  - BRANCH:   SrcA=1 SrcB=00 ALUOp=01 PCSrc=1 Branch=1 -> FETCH
//  - ADDIEX:   SrcA=1 SrcB=10 ALUOp=00 -> ADDIWB
//  - ADDIWB:   RegDst=0 MemToReg=0 RegWrite=1 -> FETCH
//  - Cycle counts, FETCH inclusive: lw 5, sw 4, R 4, beq 3, addi 4, illegal 2.
//  - ALU decode: ALUOp 00->010, 01->110, 10->Funct:
//    100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
//  - Unknown Funct: ALUControl=010. illegal_op pulses in DECODE for an R-type with unknown Funct;
//    that instruction still runs its 4 cycles.
//  - Reset: state=FETCH asynchronously. While reset=1, IRWrite, PCWrite, MemWrite, RegWrite and
//    Branch are forced 0 and illegal_op=0. The first FETCH write happens on the first edge after release.
//  - Reset asserted mid-instruction aborts it immediately; no partial write is issued after assertion.
//  - Opcode/Funct are sampled only in DECODE, MEMADR and ALU-decode states.
//    The IR is stable there because IRWrite is asserted only in FETCH.
// CONFIGURATION
//  ADDI_SUPPORT_EN defined: addi enters ADDIEX/ADDIWB.
//  Not defined: ADDIEX/ADDIWB are not generated; addi is illegal (illegal_op pulse, DECODE -> FETCH).
// STRUCTURE
//  - Shared header controller/mips_defs.vh: opcode and funct codes, state encodings,
//    ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), ALUControl codes.
//  - Sub-module alu_decoder (ALUOp, Funct -> ALUControl, funct_illegal): combinational.
//  - mips_controller holds the state register, next-state logic and output decode.
// TESTING
//  1. Reset held 3 cycles, then released with Opcode=000000: write enables stay 0 during reset;
//     first edge after release gives state=DECODE.
//  2. lw: Opcode=100011 -> states 0,1,2,3,4,0. RegWrite=1 and MemToReg=1 only in state 4.
//  3. sw, then R-type Funct=101010: sw -> 0,1,2,5,0 with MemWrite=1 once.
//     R-type -> 0,1,6,7,0 with ALUControl=111 in EXECUTE and RegDst=1 in ALUWB.
//  4. beq: Opcode=000100 -> 0,1,8,0. In BRANCH: Branch=1, PCSrc=1, ALUControl=110, PCWrite=0.
//  5. Opcode=111111: illegal_op pulses one cycle in DECODE, then FETCH; no RegWrite/MemWrite.
//     addi Opcode=001000 -> 0,1,9,10,0 with macro defined, illegal path without.
//  6. Reset asserted in MEMWRITE: MemWrite drops to 0 combinationally and state=FETCH
//     without waiting for a clock edge.

Source files
------------

// File: rtl/mips_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, funct codes, ALU codes.
package mips_controller_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StAddiEx   = 4'd9,
        StAddiWb   = 4'd10
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluCtlAdd = 3'b010;
    localparam logic [2:0] AluCtlSub = 3'b110;
    localparam logic [2:0] AluCtlAnd = 3'b000;
    localparam logic [2:0] AluCtlOr  = 3'b001;
    localparam logic [2:0] AluCtlSlt = 3'b111;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and Funct to ALUControl and flags unknown Funct codes.
module mips_controller_alu_decoder
    import mips_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    logic [2:0] funct_ctl;

    // Funct legality is reported regardless of ALUOp so DECODE can flag bad R-types.
    always_comb begin
        funct_illegal = 1'b0;
        funct_ctl     = AluCtlAdd;
        case (funct)
            FnAdd:   funct_ctl = AluCtlAdd;
            FnSub:   funct_ctl = AluCtlSub;
            FnAnd:   funct_ctl = AluCtlAnd;
            FnOr:    funct_ctl = AluCtlOr;
            FnSlt:   funct_ctl = AluCtlSlt;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (alu_op)
            AluOpSub:   alu_control = AluCtlSub;
            AluOpFunct: alu_control = funct_ctl;
            default:    alu_control = AluCtlAdd;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing lw/sw/R-type/beq plus ALU decode.
// Define ADDI_SUPPORT_EN to add the addi path (ADDIEX/ADDIWB); otherwise addi is illegal.
module mips_controller
    import mips_controller_pkg::*;
#(
    parameter logic [1:0] BRANCH_SRCB = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       IorD,
    output logic       PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_e     state_q;
    logic [1:0] alu_op;
    logic       funct_illegal;
    logic       op_known;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch: state_q <= StDecode;
                StDecode: begin
                    case (Opcode)
                        OpLw, OpSw: state_q <= StMemAdr;
                        OpRtype:    state_q <= StExecute;
                        OpBeq:      state_q <= StBranch;
`ifdef ADDI_SUPPORT_EN
                        OpAddi:     state_q <= StAddiEx;
`endif
                        default:    state_q <= StFetch;
                    endcase
                end
                StMemAdr:   state_q <= (Opcode == OpLw) ? StMemRead : StMemWrite;
                StMemRead:  state_q <= StMemWb;
                StMemWb:    state_q <= StFetch;
                StMemWrite: state_q <= StFetch;
                StExecute:  state_q <= StAluWb;
                StAluWb:    state_q <= StFetch;
                StBranch:   state_q <= StFetch;
`ifdef ADDI_SUPPORT_EN
                StAddiEx:   state_q <= StAddiWb;
                StAddiWb:   state_q <= StFetch;
`endif
                default:    state_q <= StFetch;
            endcase
        end
    end

    assign state = state_q;

    always_comb begin
        case (Opcode)
            OpLw, OpSw, OpRtype, OpBeq: op_known = 1'b1;
`ifdef ADDI_SUPPORT_EN
            OpAddi:                     op_known = 1'b1;
`endif
            default:                    op_known = 1'b0;
        endcase
    end

    always_comb begin
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        IorD       = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        alu_op     = AluOpAdd;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcB = 2'b01;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            StDecode: begin
                ALUSrcB    = BRANCH_SRCB;
                illegal_op = !op_known || ((Opcode == OpRtype) && funct_illegal);
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRead: IorD = 1'b1;
            StMemWb: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            StMemWrite: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                alu_op  = AluOpFunct;
            end
            StAluWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 1'b1;
                alu_op  = AluOpSub;
                PCSrc   = 1'b1;
                Branch  = 1'b1;
            end
`ifdef ADDI_SUPPORT_EN
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StAddiWb: RegWrite = 1'b1;
`endif
            default: ;
        endcase
        // Reset suppresses writes immediately, without waiting for the state register.
        if (reset) begin
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

    mips_controller_alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (ALUControl),
        .funct_illegal (funct_illegal)
    );

endmodule

// File: tb/tb_mips_controller.sv
// Randomized scoreboard bench for mips_controller; expected per-cycle outputs come from a
// state-path model of each instruction class.
module tb_mips_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       m2r;
        logic       rdst;
        logic       iord;
        logic       pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic       irw;
        logic       memw;
        logic       pcw;
        logic       br;
        logic       regw;
        logic       ill;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       MemToReg, RegDst, IorD, PCSrc, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       IRWrite, MemWrite, PCWrite, Branch, RegWrite;
    logic [3:0] state;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];
    int   tag_q[$];
    int   instr_no = 0;

    mips_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .MemToReg   (MemToReg),
        .RegDst     (RegDst),
        .IorD       (IorD),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .RegWrite   (RegWrite),
        .state      (state),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit addi_on();
`ifdef ADDI_SUPPORT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit fn_known(logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] fn_ctrl(logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit op_known(logic [5:0] op);
        if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100}) return 1'b1;
        return (op == 6'b001000) && addi_on();
    endfunction

    // Expected observable outputs for one cycle in state st while the IR holds op/fn.
    function automatic obs_t expect_out(int st, logic [5:0] op, logic [5:0] fn);
        obs_t e;
        e      = '0;
        e.st   = 4'(st);
        e.aluc = 3'b010;
        case (st)
            0: begin e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1; end
            1: begin
                e.srcb = 2'b11;
                e.ill  = !op_known(op) || (op == 6'b000000 && !fn_known(fn));
            end
            2: begin e.srca = 1'b1; e.srcb = 2'b10; end
            3: e.iord = 1'b1;
            4: begin e.m2r = 1'b1; e.regw = 1'b1; end
            5: begin e.iord = 1'b1; e.memw = 1'b1; end
            6: begin e.srca = 1'b1; e.aluc = fn_ctrl(fn); end
            7: begin e.rdst = 1'b1; e.regw = 1'b1; end
            8: begin e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 1'b1; e.br = 1'b1; end
            9: begin e.srca = 1'b1; e.srcb = 2'b10; end
            10: e.regw = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Pushes the expected cycles of one instruction; returns the number of cycles it takes.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, output int n);
        int path[$];
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b001000: if (addi_on()) path = '{0, 1, 9, 10}; else path = '{0, 1};
            default:   path = '{0, 1};
        endcase
        foreach (path[i]) begin
            exp_q.push_back(expect_out(path[i], op, fn));
            tag_q.push_back(instr_no);
        end
        instr_no++;
        n = path.size();
    endtask

    // Called in a FETCH cycle just after the clock edge; returns in the next FETCH cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        int n;
        Opcode = op;
        Funct  = fn;
        push_instr(op, fn, n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every non-reset cycle against the scoreboard head.
    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        int   t;
        a = {state, MemToReg, RegDst, IorD, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
             IRWrite, MemWrite, PCWrite, Branch, RegWrite, illegal_op};
        if (reset) begin
            checks++;
            if (a.st != 4'd0 || a.irw || a.memw || a.pcw || a.br || a.regw || a.ill) begin
                errors++;
                $display("FAIL reset_hold: got state=%0d wen=%b%b%b%b%b ill=%b, need state=0 all 0",
                         a.st, a.irw, a.memw, a.pcw, a.br, a.regw, a.ill);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL instr%0d_cycle: got %h (state=%0d) need %h (state=%0d)",
                         t, a, a.st, e, e.st);
            end
        end
    end

    initial begin
        logic [5:0] ops[5];
        logic [5:0] fns[5];
        logic [5:0] op;
        logic [5:0] fn;
        int         n;

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset  = 1'b1;
        Opcode = 6'b000000;
        Funct  = 6'b100000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'b000000, 6'b100000);
        run_instr(6'b100011, 6'b000000);
        run_instr(6'b101011, 6'b000000);
        run_instr(6'b000000, 6'b101010);
        run_instr(6'b000100, 6'b000000);
        run_instr(6'b111111, 6'b000000);
        run_instr(6'b001000, 6'b000000);
        run_instr(6'b000000, 6'b111111);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3, 4: op = ops[$urandom_range(0, 4)];
                default:       op = 6'($urandom);
            endcase
            if ($urandom_range(0, 3) != 0) fn = fns[$urandom_range(0, 4)];
            else fn = 6'($urandom);
            run_instr(op, fn);
        end

        // Abort a store in MEMWRITE: the write must drop with no clock edge.
        Opcode = 6'b101011;
        Funct  = 6'b000000;
        push_instr(Opcode, Funct, n);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL reset_abort: got MemWrite=%b state=%0d need MemWrite=0 state=0",
                     MemWrite, state);
        end
        void'(exp_q.pop_back());
        void'(tag_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(6'b100011, 6'b000000);
        run_instr(6'b000100, 6'b000000);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending need 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
